// File: rtl/mvm_pkg.sv
// Shared types and width helpers for the streaming matrix-vector multiplier.
// Optional saturation is selected with the MVM_SAT_EN macro.
package mvm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadX,
    StCompute,
    StOutput
  } state_t;

  // Counter width for a range of n entries; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned prod_w(input int unsigned iw);
    return 2 * iw;
  endfunction

endpackage

// File: rtl/mvm_mac.sv
// Signed multiply-accumulate slice with accumulator register.
// With MVM_SAT_EN defined the accumulate clamps to the OW signed range and flags it.
module mvm_mac
  import mvm_pkg::*;
#(
  parameter int unsigned IW = 8,
  parameter int unsigned OW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic signed [IW-1:0] a_i,
  input  logic signed [IW-1:0] b_i,
  output logic signed [OW-1:0] sum_o
`ifdef MVM_SAT_EN
  ,
  output logic                 sat_o
`endif
);

  localparam int unsigned PW = prod_w(IW);

  logic signed [PW-1:0] prod;
  logic signed [OW-1:0] prod_ext;
  logic signed [OW-1:0] base;
  logic signed [OW-1:0] acc_q, acc_d;

  assign prod     = a_i * b_i;
  assign prod_ext = OW'(prod);
  // First column of a row starts from zero instead of the previous row's total.
  assign base     = clr_i ? '0 : acc_q;

`ifdef MVM_SAT_EN
  logic signed [OW:0] sum_wide;

  always_comb begin
    sum_wide = (OW + 1)'(base) + (OW + 1)'(prod_ext);
    sat_o    = 1'b0;
    sum_o    = sum_wide[OW-1:0];
    if (sum_wide[OW] != sum_wide[OW-1]) begin
      sat_o = 1'b1;
      sum_o = sum_wide[OW] ? {1'b1, {(OW - 1){1'b0}}} : {1'b0, {(OW - 1){1'b1}}};
    end
  end
`else
  always_comb begin
    sum_o = base + prod_ext;
  end
`endif

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mvm_stream.sv
// Streaming y = A*x engine: loads A (optional, reusable) and x, computes one MAC per cycle,
// then streams y out. Saturating accumulation is enabled by the MVM_SAT_EN macro.
module mvm_stream
  import mvm_pkg::*;
#(
  parameter int unsigned M  = 4,
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 8,
  parameter int unsigned OW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [IW-1:0] s_data,
  input  logic                 load_mat,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [OW-1:0] m_data,
  output logic                 m_last,
  output logic                 ovf
);

  localparam int unsigned MN = M * N;
  localparam int unsigned AW = cnt_w(MN);
  localparam int unsigned XW = cnt_w(N);
  localparam int unsigned YW = cnt_w(M);

  if (OW < 2 * IW) begin : gen_bad_ow
    $error("mvm_stream: OW must be at least 2*IW");
  end

  state_t state_q, state_d;

  logic [AW-1:0] a_cnt_q, a_cnt_d;
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_idx_q, y_idx_d;
  logic          mat_vld_q, mat_vld_d;

  logic signed [IW-1:0] a_mem [MN];
  logic signed [IW-1:0] x_mem [N];
  logic signed [OW-1:0] y_mem [M];

  logic s_fire, m_fire;
  logic a_end, x_end, y_end;
  logic load_a_sel;
  logic a_we, x_we, y_we, mac_en;
  logic signed [OW-1:0] mac_sum;

  assign s_fire     = s_valid & s_ready;
  assign m_fire     = m_valid & m_ready;
  assign a_end      = (a_cnt_q == AW'(MN - 1));
  assign x_end      = (x_cnt_q == XW'(N - 1));
  assign y_end      = (y_idx_q == YW'(M - 1));
  assign load_a_sel = load_mat | ~mat_vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (s_fire) begin
          if (load_a_sel) begin
            state_d = a_end ? StLoadX : StLoadA;
          end else begin
            state_d = x_end ? StCompute : StLoadX;
          end
        end
      end
      StLoadA:   if (s_fire && a_end) state_d = StLoadX;
      StLoadX:   if (s_fire && x_end) state_d = StCompute;
      StCompute: if (a_end) state_d = StOutput;
      StOutput:  if (m_fire && y_end) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    a_we    = 1'b0;
    x_we    = 1'b0;
    mac_en  = 1'b0;
    y_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_ready = 1'b1;
        a_we    = s_fire & load_a_sel;
        x_we    = s_fire & ~load_a_sel;
      end
      StLoadA: begin
        s_ready = 1'b1;
        a_we    = s_fire;
      end
      StLoadX: begin
        s_ready = 1'b1;
        x_we    = s_fire;
      end
      StCompute: begin
        mac_en = 1'b1;
        y_we   = x_end;
      end
      StOutput: begin
        m_valid = 1'b1;
        m_last  = y_end;
      end
      default: ;
    endcase
  end

  // a_cnt/x_cnt double as compute read addresses and y_idx as row then output index;
  // each has wrapped back to zero by the time the next phase starts.
  always_comb begin
    a_cnt_d   = a_cnt_q;
    x_cnt_d   = x_cnt_q;
    y_idx_d   = y_idx_q;
    mat_vld_d = mat_vld_q;
    if (a_we || mac_en) begin
      a_cnt_d = a_end ? '0 : a_cnt_q + AW'(1);
    end
    if (x_we || mac_en) begin
      x_cnt_d = x_end ? '0 : x_cnt_q + XW'(1);
    end
    if (y_we || m_fire) begin
      y_idx_d = y_end ? '0 : y_idx_q + YW'(1);
    end
    if (a_we && a_end) begin
      mat_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt_q   <= '0;
      x_cnt_q   <= '0;
      y_idx_q   <= '0;
      mat_vld_q <= 1'b0;
    end else begin
      a_cnt_q   <= a_cnt_d;
      x_cnt_q   <= x_cnt_d;
      y_idx_q   <= y_idx_d;
      mat_vld_q <= mat_vld_d;
    end
  end

  // Storage arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[a_cnt_q] <= s_data;
    if (x_we) x_mem[x_cnt_q] <= s_data;
    if (y_we) y_mem[y_idx_q] <= mac_sum;
  end

  assign m_data = y_mem[y_idx_q];

`ifdef MVM_SAT_EN
  logic mac_sat;
  logic ovf_q, ovf_d;

  mvm_mac #(
    .IW(IW),
    .OW(OW)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .en_i (mac_en),
    .clr_i(x_cnt_q == '0),
    .a_i  (a_mem[a_cnt_q]),
    .b_i  (x_mem[x_cnt_q]),
    .sum_o(mac_sum),
    .sat_o(mac_sat)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StIdle && s_fire) begin
      ovf_d = 1'b0;
    end
    if (mac_en && mac_sat) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  mvm_mac #(
    .IW(IW),
    .OW(OW)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .en_i (mac_en),
    .clr_i(x_cnt_q == '0),
    .a_i  (a_mem[a_cnt_q]),
    .b_i  (x_mem[x_cnt_q]),
    .sum_o(mac_sum)
  );

  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_stream.sv
// Self-checking bench for mvm_stream (M=2, N=3, IW=8, OW=16) against a plain arithmetic model.
module tb_mvm_stream;

  localparam int unsigned M  = 2;
  localparam int unsigned N  = 3;
  localparam int unsigned IW = 8;
  localparam int unsigned OW = 16;
  localparam int MaxV = 32767;
  localparam int MinV = -32768;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [IW-1:0] s_data = '0;
  logic                 load_mat = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic signed [OW-1:0] m_data;
  logic                 m_last;
  logic                 ovf;

  int errors = 0;
  int checks = 0;

  int  job_a [M*N];
  int  job_x [N];
  int  a_ref [M*N];
  int  x_ref [N];
  int  y_ref [M];
  bit  ovf_ref;
  bit  have_mat = 1'b0;
  int  got   [M];
  bit  got_ovf;

  mvm_stream #(
    .M (M),
    .N (N),
    .IW(IW),
    .OW(OW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .load_mat(load_mat),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int wrap_ow(input longint v);
    logic [63:0] bits;
    logic signed [OW-1:0] t;
    bits = v;
    t = bits[OW-1:0];
    return int'(t);
  endfunction

  // y[i] = sum_j A[i][j]*x[j], clamped per accumulate when saturation is built in.
  function automatic void compute_ref();
    longint acc;
    ovf_ref = 1'b0;
    for (int i = 0; i < M; i++) begin
      acc = 0;
      for (int j = 0; j < N; j++) begin
        acc += longint'(a_ref[i*N+j]) * longint'(x_ref[j]);
`ifdef MVM_SAT_EN
        if (acc > MaxV) begin
          acc = MaxV;
          ovf_ref = 1'b1;
        end else if (acc < MinV) begin
          acc = MinV;
          ovf_ref = 1'b1;
        end
`endif
      end
      y_ref[i] = wrap_ow(acc);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    have_mat = 1'b0;
  endtask

  task automatic send_word(input int d, input bit lm);
    int t;
    logic [31:0] dv;
    t = 0;
    dv = d;
    @(negedge clk);
    s_valid  = 1'b1;
    s_data   = dv[IW-1:0];
    load_mat = lm;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, t);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // mode 1: always ready, 2: stall y[0] for 5 cycles, 3: random m_ready.
  task automatic recv(input int mode);
    int k, t, stall;
    logic signed [OW-1:0] exp_d;
    k = 0;
    t = 0;
    stall = 0;
    while (k < M && t < 200) begin
      @(negedge clk);
      t++;
      case (mode)
        2:       m_ready = !(k == 0 && stall < 5);
        3:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      if (m_valid) begin
        exp_d = OW'(y_ref[k]);
        checks++;
        if (m_data !== exp_d) begin
          errors++;
          $display("FAIL y_data[%0d]: got %0d, required %0d", k, m_data, exp_d);
        end
        checks++;
        if (m_last !== (k == M - 1)) begin
          errors++;
          $display("FAIL m_last[%0d]: got %0b, required %0b", k, m_last, (k == M - 1));
        end
        checks++;
        if (ovf !== ovf_ref) begin
          errors++;
          $display("FAIL ovf[%0d]: got %0b, required %0b", k, ovf, ovf_ref);
        end
        if (mode == 2 && k == 0 && !m_ready) stall++;
        if (m_ready) begin
          got[k] = int'(m_data);
          got_ovf = ovf;
          k++;
        end
      end
    end
    checks++;
    if (k != M) begin
      errors++;
      $display("FAIL recv_timeout: got %0d words, required %0d", k, M);
    end
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL back_to_idle: m_valid=%0b s_ready=%0b, required 0/1", m_valid, s_ready);
    end
  endtask

  task automatic run_job(input bit lm, input int mode);
    bit need_a;
    need_a = lm || !have_mat;
    if (need_a) begin
      a_ref = job_a;
      have_mat = 1'b1;
    end
    x_ref = job_x;
    compute_ref();
    if (need_a) begin
      for (int i = 0; i < M * N; i++) send_word(job_a[i], lm);
    end
    for (int j = 0; j < N; j++) send_word(job_x[j], lm);
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL compute_entry: s_ready=%0b m_valid=%0b, required 0/0", s_ready, m_valid);
    end
    if (mode != 0) recv(mode);
  endtask

  task automatic rand_job();
    for (int i = 0; i < M * N; i++) job_a[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < N; j++) job_x[j] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready: got %0b, required 1", s_ready);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_m_valid: got %0b, required 0", m_valid);
    end
    checks++;
    if (m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_m_last: got %0b, required 0", m_last);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %0b, required 0", ovf);
    end
  endtask

  task automatic test_basic();
    job_a = '{1, 2, 3, 4, 5, 6};
    job_x = '{1, 1, 1};
    run_job(1'b1, 1);
    checks++;
    if (got[0] != 6 || got[1] != 15 || got_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_y: got %0d,%0d ovf=%0b, required 6,15 ovf=0", got[0], got[1], got_ovf);
    end
  endtask

  task automatic test_reuse();
    job_x = '{2, 0, -1};
    run_job(1'b0, 1);
    checks++;
    if (got[0] != -1 || got[1] != 2) begin
      errors++;
      $display("FAIL reuse_y: got %0d,%0d, required -1,2", got[0], got[1]);
    end
  endtask

  task automatic test_no_matrix();
    do_reset();
    rand_job();
    run_job(1'b0, 1);
  endtask

  task automatic test_backpressure();
    job_a = '{1, 2, 3, 4, 5, 6};
    job_x = '{1, 1, 1};
    run_job(1'b1, 2);
    checks++;
    if (got[0] != 6 || got[1] != 15) begin
      errors++;
      $display("FAIL backpressure_y: got %0d,%0d, required 6,15", got[0], got[1]);
    end
  endtask

  task automatic test_overflow();
    int  exp_y;
    bit  exp_ovf;
`ifdef MVM_SAT_EN
    exp_y = 32767;
    exp_ovf = 1'b1;
`else
    exp_y = -17149;
    exp_ovf = 1'b0;
`endif
    for (int i = 0; i < M * N; i++) job_a[i] = 127;
    for (int j = 0; j < N; j++) job_x[j] = 127;
    run_job(1'b1, 1);
    checks++;
    if (got[0] != exp_y || got[1] != exp_y || got_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL overflow_y: got %0d,%0d ovf=%0b, required %0d,%0d ovf=%0b",
               got[0], got[1], got_ovf, exp_y, exp_y, exp_ovf);
    end
    // Following job must start with ovf cleared.
    job_x = '{0, 0, 1};
    run_job(1'b0, 1);
  endtask

  task automatic test_reset_compute();
    rand_job();
    run_job(1'b1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    have_mat = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_m_valid: cycle %0d got %0b, required 0", c, m_valid);
      end
    end
    rand_job();
    run_job(1'b0, 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      rand_job();
      run_job(1'($urandom_range(0, 1)), 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reuse();
    test_no_matrix();
    test_backpressure();
    test_overflow();
    test_reset_compute();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
